// File: rtl/dm_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter between the processor and the loader.
package dm_arb_pkg;

  localparam int DEF_ADDR_W   = 20;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_MAX_WAIT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } owner_e;

  function automatic owner_e other_owner(input owner_e o);
    return (o == OWN_CPU) ? OWN_LDR : OWN_CPU;
  endfunction

  // Counter must be able to hold MAX_WAIT itself; never narrower than one bit.
  function automatic int wait_width(input int max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// Combinational winner selection for the arbiter.
// DM_ARB_RR_EN selects round-robin; otherwise fixed cpu priority with loader anti-starvation.
module dm_arb_pick
  import dm_arb_pkg::*;
`ifndef DM_ARB_RR_EN
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT,
  parameter int WAIT_W   = wait_width(DEF_MAX_WAIT)
)
`endif
(
  input  logic              cpu_req,
  input  logic              ldr_req,
`ifdef DM_ARB_RR_EN
  input  owner_e            rr_ptr,
`else
  input  logic [WAIT_W-1:0] wait_cnt,
`endif
  output logic              grant_valid,
  output owner_e            winner
);

  always_comb begin
    grant_valid = cpu_req | ldr_req;
    winner      = OWN_CPU;
    if (cpu_req && ldr_req) begin
`ifdef DM_ARB_RR_EN
      winner = rr_ptr;
`else
      winner = (wait_cnt == WAIT_W'(MAX_WAIT)) ? OWN_LDR : OWN_CPU;
`endif
    end else if (ldr_req) begin
      winner = OWN_LDR;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-master data-memory arbiter: IDLE picks an owner, ACCESS drives memory, RESP acks.
// Define DM_ARB_RR_EN for round-robin; default build is fixed priority with MAX_WAIT anti-starvation.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_ack,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              dm_flag,
  output logic [ADDR_W-1:0] dm_address,
  output logic [DATA_W-1:0] dm_data,
  input  logic [DATA_W-1:0] dm_read,
  output logic              busy
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;

  logic              grant_valid;
  owner_e            winner;
  logic              owner_we;
  logic [ADDR_W-1:0] owner_addr;
  logic [DATA_W-1:0] owner_wdata;

`ifdef DM_ARB_RR_EN
  owner_e rr_q, rr_d;

  dm_arb_pick u_pick (
    .cpu_req     (cpu_req),
    .ldr_req     (ldr_req),
    .rr_ptr      (rr_q),
    .grant_valid (grant_valid),
    .winner      (winner)
  );
`else
  localparam int WAIT_W = wait_width(MAX_WAIT);
  logic [WAIT_W-1:0] wait_q, wait_d;

  dm_arb_pick #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_pick (
    .cpu_req     (cpu_req),
    .ldr_req     (ldr_req),
    .wait_cnt    (wait_q),
    .grant_valid (grant_valid),
    .winner      (winner)
  );
`endif

  always_comb begin
    owner_we    = (owner_q == OWN_LDR) ? ldr_we    : cpu_we;
    owner_addr  = (owner_q == OWN_LDR) ? ldr_addr  : cpu_addr;
    owner_wdata = (owner_q == OWN_LDR) ? ldr_wdata : cpu_wdata;
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;
`ifdef DM_ARB_RR_EN
    rr_d        = rr_q;
`else
    wait_d      = wait_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d = ACCESS;
          owner_d = winner;
`ifdef DM_ARB_RR_EN
          rr_d    = other_owner(winner);
`else
          if (winner == OWN_LDR) begin
            wait_d = '0;
          end else if (ldr_req && (wait_q != WAIT_W'(MAX_WAIT))) begin
            wait_d = wait_q + WAIT_W'(1);
          end
`endif
        end
      end
      ACCESS: begin
        state_d = RESP;
        // Memory read data is valid by the edge that ends ACCESS; writes leave rdata alone.
        if (!owner_we) begin
          if (owner_q == OWN_LDR) begin
            ldr_rdata_d = dm_read;
          end else begin
            cpu_rdata_d = dm_read;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
`ifdef DM_ARB_RR_EN
      rr_q        <= OWN_CPU;
`else
      wait_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
`ifdef DM_ARB_RR_EN
      rr_q        <= rr_d;
`else
      wait_q      <= wait_d;
`endif
    end
  end

  // Outputs decode straight from state so an asynchronous reset drops them at once.
  always_comb begin
    dm_flag    = 1'b0;
    dm_address = '0;
    dm_data    = '0;
    cpu_ack    = 1'b0;
    ldr_ack    = 1'b0;
    if (state_q == ACCESS) begin
      dm_flag    = owner_we;
      dm_address = owner_addr;
      dm_data    = owner_wdata;
    end
    if (state_q == RESP) begin
      cpu_ack = (owner_q == OWN_CPU);
      ldr_ack = (owner_q == OWN_LDR);
    end
  end

  assign busy      = (state_q != IDLE);
  assign cpu_rdata = cpu_rdata_q;
  assign ldr_rdata = ldr_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: directed transactions push expected acks, a monitor pops and compares.
// Build with DM_ARB_RR_EN defined to check the round-robin grant order instead of fixed priority.
module tb_dm_arbiter;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 32;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              ldr_req = 1'b0, ldr_we = 1'b0;
  logic [ADDR_W-1:0] ldr_addr = '0;
  logic [DATA_W-1:0] ldr_wdata = '0;
  logic              ldr_ack;
  logic [DATA_W-1:0] ldr_rdata;
  logic              dm_flag;
  logic [ADDR_W-1:0] dm_address;
  logic [DATA_W-1:0] dm_data;
  logic [DATA_W-1:0] dm_read;
  logic              busy;

  typedef struct {
    logic        is_ldr;
    logic [31:0] cpu_rd;
    logic [31:0] ldr_rd;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          ack_total = 0;
  int          cpu_ack_cnt = 0;
  int          ldr_ack_cnt = 0;
  logic [31:0] model_cpu_rd = '0;
  logic [31:0] model_ldr_rd = '0;

  logic [31:0] mem [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  dm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .ldr_req    (ldr_req),
    .ldr_we     (ldr_we),
    .ldr_addr   (ldr_addr),
    .ldr_wdata  (ldr_wdata),
    .ldr_ack    (ldr_ack),
    .ldr_rdata  (ldr_rdata),
    .dm_flag    (dm_flag),
    .dm_address (dm_address),
    .dm_data    (dm_data),
    .dm_read    (dm_read),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  // Memory model: writes land on the rising edge, read data settles mid-cycle.
  always @(posedge clock) begin
    if (dm_flag) mem[dm_address[7:0]] <= dm_data;
    else if (pl_en) mem[pl_addr] <= pl_data;
  end

  always @(negedge clock) dm_read <= mem[dm_address[7:0]];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (cpu_ack || ldr_ack) begin
      ack_total++;
      if (cpu_ack) cpu_ack_cnt++;
      if (ldr_ack) ldr_ack_cnt++;
      if (sb.size() == 0) begin
        checkOutput("unexpected_ack", {62'd0, cpu_ack, ldr_ack}, 64'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("ack_owner", {62'd0, cpu_ack, ldr_ack}, e.is_ldr ? 64'd1 : 64'd2);
        checkOutput("cpu_rdata", {32'd0, cpu_rdata}, {32'd0, e.cpu_rd});
        checkOutput("ldr_rdata", {32'd0, ldr_rdata}, {32'd0, e.ldr_rd});
      end
    end
  end

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(posedge clock); #1;
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(posedge clock); #1;
    pl_en = 1'b0;
  endtask

  task automatic push_exp(input logic is_ldr);
    exp_t e;
    e.is_ldr = is_ldr;
    e.cpu_rd = model_cpu_rd;
    e.ldr_rd = model_ldr_rd;
    sb.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_busy"}, {63'd0, busy}, 64'd0);
    checkOutput({tag, "_acks"}, {62'd0, cpu_ack, ldr_ack}, 64'd0);
    checkOutput({tag, "_dm_flag"}, {63'd0, dm_flag}, 64'd0);
    checkOutput({tag, "_dm_address"}, {44'd0, dm_address}, 64'd0);
    checkOutput({tag, "_dm_data"}, {32'd0, dm_data}, 64'd0);
    checkOutput({tag, "_rdata"}, {cpu_rdata, ldr_rdata}, 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check_reset_outputs("rst");
    @(posedge clock); #1;
    reset = 1'b1;
    model_cpu_rd = '0;
    model_ldr_rd = '0;
  endtask

  // One isolated transaction: checks latency, write strobe count and write payload.
  task automatic applyStimulus(input logic is_ldr, input logic we, input logic [19:0] a,
                               input logic [31:0] wd, input logic [31:0] mem_val);
    int          lat = 0;
    int          flags = 0;
    bit          got = 0;
    logic [19:0] fa = '0;
    logic [31:0] fd = '0;
    if (!we) begin
      if (is_ldr) model_ldr_rd = mem_val;
      else model_cpu_rd = mem_val;
    end
    push_exp(is_ldr);
    @(posedge clock); #1;
    if (is_ldr) begin
      ldr_req = 1'b1; ldr_we = we; ldr_addr = a; ldr_wdata = wd;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      lat++;
      if (dm_flag) begin
        flags++; fa = dm_address; fd = dm_data;
      end
      if (is_ldr ? ldr_ack : cpu_ack) got = 1;
    end
    checkOutput("ack_seen", {63'd0, got}, 64'd1);
    checkOutput("latency", 64'(lat), 64'd3);
    checkOutput("dm_flag_cycles", 64'(flags), we ? 64'd1 : 64'd0);
    if (we) begin
      checkOutput("dm_address", {44'd0, fa}, {44'd0, a});
      checkOutput("dm_data", {32'd0, fd}, {32'd0, wd});
    end
    @(posedge clock); #1;
    if (is_ldr) ldr_req = 1'b0;
    else cpu_req = 1'b0;
  endtask

  initial begin
    int  target;
    int  cpu_before;
    int  ldr_before;
    bit  done;
    logic is_ldr;

    $display("[TB] start");
    preload(8'h10, 32'hDEADBEEF);
    preload(8'h20, 32'hC0DE0020);
    preload(8'h24, 32'h1DA00024);
    @(negedge clock);
    check_reset_outputs("init");
    @(posedge clock); #1;
    reset = 1'b1;

    applyStimulus(1'b0, 1'b0, 20'h00010, 32'h0, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b1, 20'h00004, 32'h12345678, 32'h0);
    applyStimulus(1'b0, 1'b0, 20'h00004, 32'h0, 32'h12345678);

    // Both masters request continuously; grant order comes from the arbitration mode.
    do_reset();
    for (int i = 0; i < 10; i++) begin
`ifdef DM_ARB_RR_EN
      is_ldr = (i % 2) == 1;
`else
      is_ldr = (i % 5) == 4;
`endif
      if (is_ldr) model_ldr_rd = 32'h1DA00024;
      else model_cpu_rd = 32'hC0DE0020;
      push_exp(is_ldr);
    end
    target = ack_total + 10;
    @(posedge clock); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00020;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 20'h00024;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clock); #1;
      if (ack_total >= target) done = 1;
    end
    checkOutput("stream_done", {63'd0, done}, 64'd1);
    @(posedge clock); #1;
    cpu_req = 1'b0; ldr_req = 1'b0;
    repeat (4) @(negedge clock);
    checkOutput("stream_drain", 64'(sb.size()), 64'd0);
    sb.delete();

    // Short cpu pulse while the loader owns the bus must vanish.
    cpu_before = cpu_ack_cnt;
    ldr_before = ldr_ack_cnt;
    model_ldr_rd = 32'h1DA00024;
    push_exp(1'b1);
    @(posedge clock); #1;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 20'h00024;
    @(posedge clock); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00010;
    @(posedge clock); #1;
    cpu_req = 1'b0;
    @(posedge clock); #1;
    ldr_req = 1'b0;
    repeat (4) @(negedge clock);
    checkOutput("pulse_busy", {63'd0, busy}, 64'd0);
    checkOutput("pulse_cpu_acks", 64'(cpu_ack_cnt - cpu_before), 64'd0);
    checkOutput("pulse_ldr_acks", 64'(ldr_ack_cnt - ldr_before), 64'd1);

    // Reset in the middle of a cpu write aborts it with no ack.
    cpu_before = cpu_ack_cnt;
    @(posedge clock); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 20'h00030; cpu_wdata = 32'hA5A5A5A5;
    @(negedge clock);
    @(negedge clock);
    checkOutput("abort_flag_before", {63'd0, dm_flag}, 64'd1);
    #1;
    reset = 1'b0;
    #1;
    check_reset_outputs("abort");
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    model_cpu_rd = '0;
    model_ldr_rd = '0;
    repeat (5) @(negedge clock);
    checkOutput("abort_busy", {63'd0, busy}, 64'd0);
    checkOutput("abort_cpu_acks", 64'(cpu_ack_cnt - cpu_before), 64'd0);
    checkOutput("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter ADDR_W, 20, data-memory address width.
REQ-002 Parameter DATA_W, 32, data word width.
REQ-003 Parameter MAX_WAIT, 4, consecutive lost arbitrations before loader is force-granted (fixed-priority mode only).
REQ-004 clock  in  1  single system clock (divided processor clock); all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 cpu_req/cpu_we  in  1/1  processor access request and write select.
REQ-007 cpu_addr/cpu_wdata  in  ADDR_W/DATA_W  processor address and store data.
REQ-008 cpu_ack/cpu_rdata  out  1/DATA_W  one-cycle completion pulse and load data.
REQ-009 ldr_req/ldr_we  in  1/1  loader (BIOS/program-load) request and write select.
REQ-010 ldr_addr/ldr_wdata  in  ADDR_W/DATA_W  loader address and data.
REQ-011 ldr_ack/ldr_rdata  out  1/DATA_W  loader completion pulse and read data.
REQ-012 dm_flag  out  1  data-memory write enable.
REQ-013 dm_address/dm_data  out  ADDR_W/DATA_W  data-memory address and write data.
REQ-014 dm_read  in  DATA_W  data-memory synchronous read port (valid one edge after address).
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS when any req high at the edge, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-017 Winner chosen in IDLE, registered as owner, held stable through ACCESS and RESP.
REQ-018 ACCESS: dm_address/dm_data driven from owner's addr/wdata; dm_flag = owner's we; all other cycles dm_flag = 0, dm_address/dm_data = 0.
REQ-019 RESP: owner's ack = 1 for exactly one cycle; for reads owner's rdata = dm_read captured at ACCESS->RESP edge; for writes rdata holds previous value.
REQ-020 Latency: req sampled at edge N -> ack high during cycle N+2; minimum 3 cycles per transaction, back-to-back throughput one access per 3 cycles.
REQ-021 Requester holds req, we, addr, wdata stable until ack; req still high in the cycle after ack counts as a new request.
REQ-022 Non-owner ack stays 0; non-owner rdata unchanged.
REQ-023 Fixed-priority mode: cpu wins simultaneous requests; wait counter (width clog2(MAX_WAIT+1)) increments each IDLE decision where ldr_req lost, clears on ldr grant; counter == MAX_WAIT forces ldr grant.
REQ-024 Lone requester always wins regardless of mode or counter.
REQ-025 Request deasserted before grant is dropped without effect; no ack generated.

Reset
REQ-026 reset low forces state IDLE, owner cpu, wait counter 0, rr pointer cpu, both acks 0, both rdata 0, dm_flag 0, dm_address 0, dm_data 0, busy 0, asynchronously.
REQ-027 Reset during ACCESS aborts the transfer: dm_flag falls immediately, no ack issued after release; requester must reissue.
REQ-028 First decision after reset release occurs at the first rising edge with reset high.

Configuration
REQ-029 Macro DM_ARB_RR_EN defined: round-robin; simultaneous requests grant the requester not granted last; pointer updates on each grant; wait counter absent.
REQ-030 Macro DM_ARB_RR_EN undefined: fixed priority with MAX_WAIT anti-starvation per REQ-023.

Structure
REQ-031 Package dm_arb_pkg holds state enum (IDLE, ACCESS, RESP), owner encoding (OWN_CPU=0, OWN_LDR=1), ADDR_W/DATA_W defaults.
REQ-032 One sub-module dm_arb_pick: combinational winner selection from reqs, rr pointer and wait counter; all registers stay in dm_arbiter.

Verification
REQ-033 cpu read only, cpu_addr=0x00010, memory word 0xDEADBEEF -> cpu_ack at cycle N+2, cpu_rdata=0xDEADBEEF, dm_flag never high.
REQ-034 ldr write addr=0x00004 data=0x12345678 -> dm_flag high exactly one cycle with those values, ldr_ack at N+2, subsequent cpu read returns 0x12345678.
REQ-035 Both req held continuously, fixed mode, MAX_WAIT=4 -> grant order cpu,cpu,cpu,cpu,ldr repeating.
REQ-036 Both req held, DM_ARB_RR_EN -> grants alternate cpu,ldr,cpu,ldr; first after reset is cpu.
REQ-037 reset pulsed low during ACCESS of a cpu write -> dm_flag drops same cycle, no cpu_ack, all outputs 0, busy 0.
REQ-038 cpu_req pulsed one cycle while ldr owns bus -> cpu never acked, arbiter returns to IDLE with busy 0.
